instr_issuer: RTL and testbench

//  Instruction-side driver for the multi-cycle core: walks a program held in a

---
 rtl/isa_pkg.sv | 25 ++
 rtl/instr_issuer.sv | 130 +++++++++++++
 tb/tb_instr_issuer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA constants for the multi-cycle core and its instruction-side driver.
// Holds default widths, the idle word, opcode values and the issuer state encoding.
package isa_pkg;

    localparam int DATA_SIZE   = 32;
    localparam int ADDR_SIZE   = 6;
    localparam int SLOT_CYCLES = 4;

    // SRLI R0,R0,0: architecturally a no-op
    localparam logic [DATA_SIZE-1:0] NOP_WORD = 32'h4000_0009;

    localparam logic [5:0] OP_ADDI  = 6'b101000;
    localparam logic [5:0] OP_MOVI  = 6'b100010;
    localparam logic [5:0] OP_ALU_1 = 6'b100000;
    localparam logic [5:0] OP_ORI   = 6'b101100;
    localparam logic [5:0] OP_XORI  = 6'b101011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_HOLD
    } issue_state_t;

endpackage

// File: rtl/instr_issuer.sv
// Walks a program in a sync-read instruction memory and holds each word on
// `instruction` for SlotCycles clocks, back-to-back, then parks on the NOP word.
module instr_issuer
    import isa_pkg::*;
#(
    parameter int                  DataSize   = DATA_SIZE,
    parameter int                  AddrSize   = ADDR_SIZE,
    parameter int                  SlotCycles = SLOT_CYCLES,
    parameter logic [DataSize-1:0] NopWord    = NOP_WORD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [AddrSize:0]   prog_len,
    output logic                im_rd,
    output logic [AddrSize-1:0] im_addr,
    input  logic [DataSize-1:0] im_dout,
    output logic [DataSize-1:0] instruction,
    output logic                insn_valid,
    output logic [AddrSize:0]   pc,
    output logic                busy,
    output logic                done
);

    localparam int PcW   = AddrSize + 1;
    localparam int SlotW = (SlotCycles > 2) ? $clog2(SlotCycles) : 1;

    localparam logic [SlotW-1:0] SlotLast = SlotW'(SlotCycles - 1);
    localparam logic [SlotW-1:0] SlotPre  = SlotW'(SlotCycles - 2);

    issue_state_t     state;
    logic [PcW-1:0]   len;
    logic [SlotW-1:0] slot;

    logic [PcW-1:0]   pc_inc;
    logic [PcW-1:0]   pc_inc2;
    logic [SlotW-1:0] slot_inc;
    logic             more;

    always_comb begin
        pc_inc   = pc + PcW'(1);
        pc_inc2  = pc + PcW'(2);
        slot_inc = slot + SlotW'(1);
        more     = (pc_inc < len);
    end

    // im_rd is registered, so the prefetch strobe is raised on the edge that
    // enters slot SlotCycles-2; the word then lands exactly at the slot boundary.
    always_ff @(posedge clk) begin
        im_rd <= 1'b0;
        done  <= 1'b0;
        if (!reset) begin
            state       <= S_IDLE;
            instruction <= NopWord;
            insn_valid  <= 1'b0;
            busy        <= 1'b0;
            im_addr     <= '0;
            pc          <= '0;
            len         <= '0;
            slot        <= '0;
        end else if (stop) begin
            state       <= S_IDLE;
            instruction <= NopWord;
            insn_valid  <= 1'b0;
            busy        <= 1'b0;
            slot        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (prog_len != '0) begin
                            state   <= S_FETCH;
                            len     <= prog_len;
                            pc      <= '0;
                            busy    <= 1'b1;
                            im_rd   <= 1'b1;
                            im_addr <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    state       <= S_HOLD;
                    instruction <= im_dout;
                    insn_valid  <= 1'b1;
                    slot        <= '0;
                    if (SlotPre == '0 && len > PcW'(1)) begin
                        im_rd   <= 1'b1;
                        im_addr <= AddrSize'(1);
                    end
                end
                S_HOLD: begin
                    if (slot == SlotLast) begin
                        if (more) begin
                            instruction <= im_dout;
                            pc          <= pc_inc;
                            slot        <= '0;
                            if (SlotPre == '0 && pc_inc2 < len) begin
                                im_rd   <= 1'b1;
                                im_addr <= AddrSize'(pc_inc2);
                            end
                        end else begin
                            state       <= S_IDLE;
                            instruction <= NopWord;
                            insn_valid  <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            slot        <= '0;
                        end
                    end else begin
                        slot <= slot_inc;
                        if (slot_inc == SlotPre && more) begin
                            im_rd   <= 1'b1;
                            im_addr <= AddrSize'(pc_inc);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_issuer.sv
// Scoreboard bench for instr_issuer: stimulus pushes expected (word, pc) per
// presented cycle; a negedge monitor pops and compares whenever insn_valid is high.
module tb_instr_issuer;
    import isa_pkg::*;

    localparam logic [31:0] NOP = 32'h4000_0009;

    typedef struct {
        logic [31:0] insn;
        logic [6:0]  pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [6:0]  prog_len;
    logic        im_rd;
    logic [5:0]  im_addr;
    logic [31:0] im_dout;
    logic [31:0] instruction;
    logic        insn_valid;
    logic [6:0]  pc;
    logic        busy;
    logic        done;

    instr_issuer #(
        .DataSize   (32),
        .AddrSize   (6),
        .SlotCycles (4),
        .NopWord    (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .prog_len    (prog_len),
        .im_rd       (im_rd),
        .im_addr     (im_addr),
        .im_dout     (im_dout),
        .instruction (instruction),
        .insn_valid  (insn_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    int          rd_cnt = 0;
    int          cyc = 0;

    always @(posedge clk) begin : im_model
        if (im_rd === 1'b1) begin
            im_dout <= mem[im_addr];
            rd_cnt  <= rd_cnt + 1;
        end
        cyc <= cyc + 1;
    end

    int   checks = 0;
    int   errors = 0;
    int   exp_done = 0;
    logic mon_en = 1'b0;
    exp_t sb[$];
    exp_t e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (insn_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h pc %0d expected none", instruction, pc);
                end else begin
                    e = sb.pop_front();
                    chk("word", instruction, e.insn);
                    chk("pc", pc, e.pc);
                end
            end else begin
                chk("idle_nop", instruction, NOP);
            end
            if (done === 1'b1) begin
                checks++;
                if (exp_done == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got 1 expected 0");
                end else begin
                    exp_done--;
                end
            end
        end
    end

    task automatic push_word(input int w, input int n);
        exp_t x;
        x.insn = mem[w];
        x.pc   = 7'(w);
        for (int k = 0; k < n; k++) sb.push_back(x);
    endtask

    task automatic launch(input int len, output int e0);
        prog_len = 7'(len);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e0    = cyc;
    endtask

    task automatic run_full(input int len, input string tag);
        int e0;
        int base;
        int lat;
        base = rd_cnt;
        for (int w = 0; w < len; w++) push_word(w, 4);
        exp_done++;
        launch(len, e0);
        chk({tag, "_busy"}, busy, 1);
        @(posedge clk); #1;
        chk({tag, "_valid_e1"}, insn_valid, 0);
        @(posedge clk); #1;
        chk({tag, "_valid_e2"}, insn_valid, 1);
        lat = -1;
        for (int k = 0; k < len * 4 + 10; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = cyc - e0;
                break;
            end
        end
        chk({tag, "_done_lat"}, lat, 2 + len * 4);
        chk({tag, "_nop_after"}, instruction, NOP);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_reads"}, rd_cnt - base, len);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int e0;
        int base;
        reset = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        prog_len = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0203;

        // 1. reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_insn", instruction, NOP);
        chk("rst_valid", insn_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_imrd", im_rd, 0);
        chk("rst_pc", pc, 0);
        chk("rst_addr", im_addr, 0);
        reset = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // 2. two-word program
        mem[0] = 32'h5000_000D;
        mem[1] = 32'h5010_800C;
        run_full(2, "t2");

        // 3. twelve-word ALU program
        mem[0]  = 32'h8800_0005; mem[1]  = 32'h8840_0014; mem[2]  = 32'h8080_4000;
        mem[3]  = 32'hA0C0_000C; mem[4]  = 32'hB100_00D0; mem[5]  = 32'hAD40_000F;
        mem[6]  = 32'h8180_6001; mem[7]  = 32'hA1C0_0018; mem[8]  = 32'hB200_00D0;
        mem[9]  = 32'h8A40_0003; mem[10] = 32'h8240_C002; mem[11] = 32'h4000_0009;
        run_full(12, "t3");

        // full address range: pc reaches 63
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101);
        run_full(64, "full");

        // 4. zero-length program
        base = rd_cnt;
        exp_done++;
        launch(0, e0);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        @(posedge clk); #1;
        chk("t4_done_clr", done, 0);
        chk("t4_busy2", busy, 0);
        chk("t4_reads", rd_cnt - base, 0);

        // 5. stop in slot 2 of word 1
        base = rd_cnt;
        push_word(0, 4);
        push_word(1, 3);
        launch(3, e0);
        repeat (8) @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        chk("t5_valid", insn_valid, 0);
        chk("t5_nop", instruction, NOP);
        chk("t5_busy", busy, 0);
        chk("t5_imrd", im_rd, 0);
        chk("t5_done", done, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_reads", rd_cnt - base, 3);
        chk("t5_sb_empty", sb.size(), 0);
        run_full(2, "t5_rerun");

        // start together with stop: stop wins
        base = rd_cnt;
        stop = 1'b1;
        launch(2, e0);
        stop = 1'b0;
        chk("ss_busy", busy, 0);
        chk("ss_imrd", im_rd, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("ss_reads", rd_cnt - base, 0);

        // 6. start while busy ignored, then reset mid-HOLD
        push_word(0, 4);
        push_word(1, 2);
        launch(3, e0);
        repeat (4) @(posedge clk);
        #1;
        prog_len = 7'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("t6_insn", instruction, NOP);
        chk("t6_valid", insn_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_imrd", im_rd, 0);
        chk("t6_pc", pc, 0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_sb_empty", sb.size(), 0);
        run_full(1, "t6_after");

        repeat (3) @(posedge clk);
        #1;
        chk("end_sb_empty", sb.size(), 0);
        chk("end_done_owed", exp_done, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
